ps2_voice_decoder: RTL and testbench

Parametrised successor to the single-note PS/2 key mapper. It consumes raw PS/2 scancode bytes, tracks make/break (F0) and extended (E0) prefixes, and holds a per-key pressed mask. It allocates up to VOICES simultaneous notes and emits buffered note-on/note-off events through a valid/ready FIFO. It sits between the PS/2 byte receiver and the synth voice bank, and also drives the octave, ADSR-select and ADSR step controls.

---
 rtl/ps2_voice_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_ps2_voice_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_voice_decoder.sv
// Polyphonic PS/2 key decoder: scancodes -> note-on/off events in a FWFT FIFO plus octave/ADSR controls.
// State updates one cycle after a strobe; events stall on evt_ready, a push into a full FIFO is dropped and flagged.
module ps2_voice_decoder #(
    parameter int VOICES      = 4,
    parameter int OCT_BITS    = 3,
    parameter int OCT_DEFAULT = 4,
    parameter int OCT_MAX     = 7,
    parameter int FIFO_DEPTH  = 4,
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                ps2_byte_valid,
    input  logic [7:0]          ps2_byte,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic                evt_on,
    output logic [3:0]          evt_note,
    output logic [OCT_BITS-1:0] evt_octave,
    output logic [VW-1:0]       evt_voice,
    output logic [11:0]         held_mask,
    output logic [OCT_BITS-1:0] octave,
    output logic [2:0]          adsr_sel,
    output logic                adsr_inc,
    output logic                adsr_dec,
    output logic                overflow
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_BREAK     = 2'd1;
    localparam logic [1:0] S_EXT       = 2'd2;
    localparam logic [1:0] S_EXT_BREAK = 2'd3;

    typedef struct packed {
        logic                on;
        logic [3:0]          note;
        logic [OCT_BITS-1:0] oct;
        logic [VW-1:0]       voice;
    } evt_t;

    logic [1:0]          state_q, state_d;
    logic [VOICES-1:0]   used_q, used_d;
    logic [3:0]          vnote_q [VOICES];
    logic [3:0]          vnote_d [VOICES];
    logic [OCT_BITS-1:0] voct_q  [VOICES];
    logic [OCT_BITS-1:0] voct_d  [VOICES];
    logic [11:0]         held_q, held_d;
    logic [OCT_BITS-1:0] oct_q, oct_d;
    logic [2:0]          sel_q, sel_d;
    logic                inc_q, inc_d, dec_q, dec_d, ovf_q, ovf_d;
    evt_t                mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_q, rd_q;
    logic [AW:0]         cnt_q;
    logic                push, push_ok, pop;
    evt_t                push_evt, head;
    logic [4:0]          key;
    logic                free_vld, hit_vld;
    logic [VW-1:0]       free_idx, hit_idx;

    // {is_note, semitone}
    function automatic logic [4:0] note_of(input logic [7:0] b);
        case (b)
            8'h1C: return {1'b1, 4'd0};
            8'h1D: return {1'b1, 4'd1};
            8'h1B: return {1'b1, 4'd2};
            8'h24: return {1'b1, 4'd3};
            8'h23: return {1'b1, 4'd4};
            8'h2B: return {1'b1, 4'd5};
            8'h2C: return {1'b1, 4'd6};
            8'h34: return {1'b1, 4'd7};
            8'h35: return {1'b1, 4'd8};
            8'h33: return {1'b1, 4'd9};
            8'h3C: return {1'b1, 4'd10};
            8'h3B: return {1'b1, 4'd11};
            default: return 5'd0;
        endcase
    endfunction

    assign key     = note_of(ps2_byte);
    assign pop     = (cnt_q != '0) && evt_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign push_ok = (cnt_q != (AW+1)'(FIFO_DEPTH)) || pop;

    always_comb begin
        free_vld = 1'b0;
        free_idx = '0;
        hit_vld  = 1'b0;
        hit_idx  = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (!used_q[i]) begin
                free_vld = 1'b1;
                free_idx = VW'(i);
            end
            if (used_q[i] && vnote_q[i] == key[3:0]) begin
                hit_vld = 1'b1;
                hit_idx = VW'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        used_d   = used_q;
        vnote_d  = vnote_q;
        voct_d   = voct_q;
        held_d   = held_q;
        oct_d    = oct_q;
        sel_d    = sel_q;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        push     = 1'b0;
        push_evt = '0;
        if (ps2_byte_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (ps2_byte == 8'hF0) begin
                        state_d = S_BREAK;
                    end else if (ps2_byte == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (key[4]) begin
                        if (!held_q[key[3:0]] && free_vld) begin
                            push           = 1'b1;
                            push_evt.on    = 1'b1;
                            push_evt.note  = key[3:0];
                            push_evt.oct   = oct_q;
                            push_evt.voice = free_idx;
                            // A dropped note-on must not leave a silent voice allocated.
                            if (push_ok) begin
                                used_d[free_idx]  = 1'b1;
                                vnote_d[free_idx] = key[3:0];
                                voct_d[free_idx]  = oct_q;
                                held_d[key[3:0]]  = 1'b1;
                            end
                        end
                    end else begin
                        case (ps2_byte)
                            8'h1A: if (oct_q != '0) oct_d = oct_q - 1'b1;
                            8'h22: if (oct_q != OCT_BITS'(OCT_MAX)) oct_d = oct_q + 1'b1;
                            8'h16: sel_d = 3'd0;
                            8'h1E: sel_d = 3'd1;
                            8'h26: sel_d = 3'd2;
                            8'h25: sel_d = 3'd3;
                            8'h2E: sel_d = 3'd4;
                            8'h21: dec_d = 1'b1;
                            8'h2A: inc_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
                S_BREAK: begin
                    if (ps2_byte != 8'hF0) begin
                        state_d = S_IDLE;
                        if (key[4] && hit_vld) begin
                            push             = 1'b1;
                            push_evt.on      = 1'b0;
                            push_evt.note    = key[3:0];
                            push_evt.oct     = voct_q[hit_idx];
                            push_evt.voice   = hit_idx;
                            used_d[hit_idx]  = 1'b0;
                            held_d[key[3:0]] = 1'b0;
                        end
                    end
                end
                S_EXT:   state_d = (ps2_byte == 8'hF0) ? S_EXT_BREAK : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        ovf_d = ovf_q | (push & ~push_ok);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            used_q  <= '0;
            held_q  <= '0;
            oct_q   <= OCT_BITS'(OCT_DEFAULT);
            sel_q   <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < VOICES; i++) begin
                vnote_q[i] <= '0;
                voct_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            used_q  <= used_d;
            vnote_q <= vnote_d;
            voct_q  <= voct_d;
            held_q  <= held_d;
            oct_q   <= oct_d;
            sel_q   <= sel_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            ovf_q   <= ovf_d;
            if (push && push_ok) wr_q <= wr_q + 1'b1;
            if (pop)             rd_q <= rd_q + 1'b1;
            case ({push && push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push && push_ok) mem_q[wr_q] <= push_evt;
    end

    assign evt_valid  = (cnt_q != '0);
    assign head       = evt_valid ? mem_q[rd_q] : '0;
    assign evt_on     = head.on;
    assign evt_note   = head.note;
    assign evt_octave = head.oct;
    assign evt_voice  = head.voice;
    assign held_mask  = held_q;
    assign octave     = oct_q;
    assign adsr_sel   = sel_q;
    assign adsr_inc   = inc_q;
    assign adsr_dec   = dec_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_ps2_voice_decoder.sv
// Directed bench: a 4-voice and an 8-voice decoder share one scancode stream; expectations are hand-computed.
module tb_ps2_voice_decoder;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       bv = 1'b0;
    logic [7:0] bd = 8'h00;
    logic       rdy = 1'b1;

    logic       v4, on4, inc4, dec4, ovf4;
    logic [3:0] note4;
    logic [2:0] oct4, evoct4, sel4;
    logic [1:0] voice4;
    logic [11:0] held4;

    logic       v8, on8, inc8, dec8, ovf8;
    logic [3:0] note8;
    logic [2:0] oct8, evoct8, sel8, voice8;
    logic [11:0] held8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_voice_decoder #(.VOICES(4)) u_dut4 (
        .CLOCK_50(clk), .resetn(rstn), .ps2_byte_valid(bv), .ps2_byte(bd),
        .evt_valid(v4), .evt_ready(rdy), .evt_on(on4), .evt_note(note4),
        .evt_octave(evoct4), .evt_voice(voice4), .held_mask(held4), .octave(oct4),
        .adsr_sel(sel4), .adsr_inc(inc4), .adsr_dec(dec4), .overflow(ovf4)
    );

    ps2_voice_decoder #(.VOICES(8)) u_dut8 (
        .CLOCK_50(clk), .resetn(rstn), .ps2_byte_valid(bv), .ps2_byte(bd),
        .evt_valid(v8), .evt_ready(rdy), .evt_on(on8), .evt_note(note8),
        .evt_octave(evoct8), .evt_voice(voice8), .held_mask(held8), .octave(oct8),
        .adsr_sel(sel8), .adsr_inc(inc8), .adsr_dec(dec8), .overflow(ovf8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One strobe cycle; returns on the falling edge right after the sampling edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bv = 1'b1;
        bd = b;
        @(negedge clk);
        bv = 1'b0;
    endtask

    task automatic burst(input logic [7:0] b, input int n);
        @(negedge clk);
        bv = 1'b1;
        bd = b;
        repeat (n) @(negedge clk);
        bv = 1'b0;
    endtask

    task automatic chk_evt4(input string tag, input logic on, input logic [3:0] note,
                            input logic [2:0] oct, input logic [1:0] voice);
        check({tag, ".vld"},   v4, 1);
        check({tag, ".on"},    on4, on);
        check({tag, ".note"},  note4, note);
        check({tag, ".oct"},   evoct4, oct);
        check({tag, ".voice"}, voice4, voice);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int n;
        logic [3:0] last_note;
        logic [2:0] last_voice;

        repeat (2) @(negedge clk);
        check("rst.vld", v4, 0);
        check("rst.on", on4, 0);
        check("rst.note", note4, 0);
        check("rst.evoct", evoct4, 0);
        check("rst.voice", voice4, 0);
        check("rst.held", held4, 0);
        check("rst.oct", oct4, 4);
        check("rst.sel", sel4, 0);
        check("rst.inc", inc4, 0);
        check("rst.dec", dec4, 0);
        check("rst.ovf", ovf8, 0);
        rstn = 1'b1;

        // single make/break
        send(8'h1C);
        chk_evt4("on_a", 1, 0, 4, 0);
        check("held_a", held4, 12'h001);
        send(8'hF0);
        check("f0_novt", v4, 0);
        send(8'h1C);
        chk_evt4("off_a", 0, 0, 4, 0);
        check("held_a0", held4, 12'h000);

        // typematic repeat and break of an unheld key
        send(8'h1C);
        chk_evt4("tm_on", 1, 0, 4, 0);
        send(8'h1C);
        check("tm_rep1", v4, 0);
        send(8'h1C);
        check("tm_rep2", v4, 0);
        send(8'hF0);
        send(8'h1B);
        check("brk_unheld", v4, 0);
        check("held_tm", held4, 12'h001);
        send(8'hF0);
        send(8'h1C);
        chk_evt4("tm_off", 0, 0, 4, 0);

        // voice allocation with 4 voices
        send(8'h1C); chk_evt4("al0", 1, 0, 4, 0);
        send(8'h1B); chk_evt4("al1", 1, 2, 4, 1);
        send(8'h23); chk_evt4("al2", 1, 4, 4, 2);
        send(8'h2B); chk_evt4("al3", 1, 5, 4, 3);
        send(8'h34); check("al4_ignored", v4, 0);
        check("held_al", held4, 12'h035);
        send(8'hF0); send(8'h1B); chk_evt4("al_off1", 0, 2, 4, 1);
        send(8'h34); chk_evt4("al_re1", 1, 7, 4, 1);
        check("held_re", held4, 12'h0B1);
        send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h23);
        send(8'hF0); send(8'h2B);
        send(8'hF0); send(8'h34); chk_evt4("al_off7", 0, 7, 4, 1);
        check("held_clr", held4, 12'h000);

        // octave saturation; note-off keeps the stored octave
        send(8'h1C); chk_evt4("oc_on", 1, 0, 4, 0);
        burst(8'h22, 5);
        check("oct_max", oct4, 7);
        send(8'hF0); send(8'h1C);
        chk_evt4("oc_off", 0, 0, 4, 0);
        burst(8'h1A, 9);
        check("oct_min", oct4, 0);

        // FIFO full / overflow
        do_reset();
        rdy = 1'b0;
        send(8'h1C); send(8'h1D); send(8'h1B); send(8'h24); send(8'h23);
        check("ov8.ovf", ovf8, 1);
        check("ov8.held", held8, 12'h00F);
        check("ov8.head_note", note8, 0);
        check("ov4.ovf", ovf4, 0);
        check("ov4.held", held4, 12'h00F);
        @(negedge clk);
        bv = 1'b1; bd = 8'h2B; rdy = 1'b1;
        @(negedge clk);
        bv = 1'b0; rdy = 1'b0;
        check("pp.held", held8, 12'h02F);
        check("pp.head_note", note8, 1);
        check("pp.head_voice", voice8, 1);
        rdy = 1'b1;
        n = 0;
        last_note = '0;
        last_voice = '0;
        for (int i = 0; i < 10; i++) begin
            if (v8) begin
                n++;
                last_note = note8;
                last_voice = voice8;
            end
            @(negedge clk);
        end
        check("drain.count", n, 4);
        check("drain.last_note", last_note, 5);
        check("drain.last_voice", last_voice, 4);
        check("drain.ovf_sticky", ovf8, 1);

        // extended codes and ADSR controls
        do_reset();
        send(8'hE0); check("e0", v4, 0);
        send(8'hF0); check("e0f0", v4, 0);
        send(8'h75); check("e0f0_75", v4, 0);
        check("ext.held", held4, 0);
        send(8'h26);
        check("sel", sel4, 2);
        send(8'h2A);
        check("inc_hi", inc4, 1);
        check("dec_lo", dec4, 0);
        @(negedge clk);
        check("inc_pulse", inc4, 0);
        send(8'h21);
        check("dec_hi", dec4, 1);

        // asynchronous reset mid-stream
        rdy = 1'b0;
        send(8'h1C);
        send(8'h22);
        check("pre.held", held4, 12'h001);
        check("pre.oct", oct4, 5);
        send(8'hF0);
        #2 rstn = 1'b0;
        #1;
        check("ar.vld", v4, 0);
        check("ar.held", held4, 0);
        check("ar.oct", oct4, 4);
        check("ar.sel", sel4, 0);
        check("ar.note", note4, 0);
        @(negedge clk);
        rstn = 1'b1;
        rdy = 1'b1;
        send(8'h1C);
        chk_evt4("ar.fresh", 1, 0, 4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
